// File: rtl/gfx_pkg.sv
// Shared graphics constants, FSM encoding and frame-address helper used by the
// terrain writer and the display-side address generators.
package gfx_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 12;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Linear address of pixel (h, v) in a SCREEN_W-pitch memory; callers only
   // rely on the result when (h, v) lies inside the frame.
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [10:0] h,
                                                    input logic [10:0] v);
      logic [31:0] a;
      a = 32'(h) + 32'(SCREEN_W) * 32'(v);
      return a[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/rect_scan.sv
// Raster counter for a width x height window: x is the inner index, y the outer,
// with a flag raised on the final pixel.
module rect_scan (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       en,
   input  logic [9:0] width,
   input  logic [9:0] height,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       last
);

   logic x_last;

   assign x_last = (x == width - 10'd1);
   assign last   = x_last && (y == height - 10'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x_last) begin
            x <= '0;
            y <= y + 10'd1;
         end else begin
            x <= x + 10'd1;
         end
      end
   end

endmodule

// File: rtl/terrain_writer.sv
// Rectangle copy engine: streams a source window into the 320x240 frame memory,
// clipping at the screen edge and optionally skipping a transparent colour.
module terrain_writer #(
   parameter int SCREEN_W = gfx_pkg::SCREEN_W,
   parameter int SCREEN_H = gfx_pkg::SCREEN_H,
   parameter int ADDR_W   = gfx_pkg::ADDR_W,
   parameter int DATA_W   = gfx_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [9:0]        src_h,
   input  logic [9:0]        src_v,
   input  logic [9:0]        dst_h,
   input  logic [9:0]        dst_v,
   input  logic [9:0]        width,
   input  logic [9:0]        height,
   input  logic              key_en,
   input  logic [DATA_W-1:0] key,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] src_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done
);

   import gfx_pkg::*;

   logic [1:0]        state;
   logic [9:0]        src_h_q, src_v_q, dst_h_q, dst_v_q, width_q, height_q;
   logic              key_en_q;
   logic [DATA_W-1:0] key_q;
   logic [9:0]        x, y;
   logic              last;
   logic              scan_clear, scan_en;
   logic [10:0]       sx, sy, dx, dy;
   logic              wr_valid, wr_in_range;
   logic [ADDR_W-1:0] waddr_q;

   assign scan_clear = (state == ST_IDLE);
   assign scan_en    = (state == ST_RUN);

   rect_scan u_scan (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (scan_clear),
      .en     (scan_en),
      .width  (width_q),
      .height (height_q),
      .x      (x),
      .y      (y),
      .last   (last)
   );

   // 11-bit sums cannot wrap, so off-screen destinations compare correctly.
   assign sx = {1'b0, src_h_q} + {1'b0, x};
   assign sy = {1'b0, src_v_q} + {1'b0, y};
   assign dx = {1'b0, dst_h_q} + {1'b0, x};
   assign dy = {1'b0, dst_v_q} + {1'b0, y};

   assign src_addr = scan_en ? xy_to_addr(sx, sy) : '0;
   assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
   assign done     = (state == ST_DONE);

   // The write stage pairs the delayed destination with the ROM output.
   assign we    = wr_valid && wr_in_range && !(key_en_q && (src_data == key_q));
   assign wdata = wr_valid ? src_data : '0;
   assign waddr = waddr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         src_h_q  <= '0;
         src_v_q  <= '0;
         dst_h_q  <= '0;
         dst_v_q  <= '0;
         width_q  <= '0;
         height_q <= '0;
         key_en_q <= 1'b0;
         key_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  src_h_q  <= src_h;
                  src_v_q  <= src_v;
                  dst_h_q  <= dst_h;
                  dst_v_q  <= dst_v;
                  width_q  <= width;
                  height_q <= height;
                  key_en_q <= key_en;
                  key_q    <= key;
                  state    <= (width == 10'd0 || height == 10'd0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN:   if (last) state <= ST_DRAIN;
            ST_DRAIN: state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid    <= 1'b0;
         wr_in_range <= 1'b0;
         waddr_q     <= '0;
      end else begin
         wr_valid    <= scan_en;
         wr_in_range <= (dx < 11'(SCREEN_W)) && (dy < 11'(SCREEN_H));
         if (scan_en) waddr_q <= xy_to_addr(dx, dy);
      end
   end

endmodule

// File: tb/tb_terrain_writer.sv
// Self-checking bench for terrain_writer: directed cases plus randomized copies
// compared cycle by cycle against a per-pixel arithmetic model.
module tb_terrain_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  src_h = '0, src_v = '0, dst_h = '0, dst_v = '0;
   logic [9:0]  width = '0, height = '0;
   logic        key_en = 1'b0;
   logic [11:0] key = '0;
   logic [16:0] src_addr;
   logic [11:0] src_data = '0;
   logic        we;
   logic [16:0] waddr;
   logic [11:0] wdata;
   logic        busy;
   logic        done;

   logic [11:0] rom [0:76799];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   terrain_writer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_h    (src_h),
      .src_v    (src_v),
      .dst_h    (dst_h),
      .dst_v    (dst_v),
      .width    (width),
      .height   (height),
      .key_en   (key_en),
      .key      (key),
      .src_addr (src_addr),
      .src_data (src_data),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done)
   );

   // Synchronous source ROM with one cycle of read latency.
   always @(posedge clk) src_data <= (int'(src_addr) < 76800) ? rom[src_addr] : 12'h000;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one copy from start to one idle cycle after done, predicting every
   // cycle from the pixel index; repulse>0 pulses start with other parameters.
   task automatic apply_stimulus(input string name, input int sh, input int sv,
                                 input int dh, input int dv, input int w, input int h,
                                 input bit ke, input logic [11:0] k, input int repulse,
                                 output int nwr);
      int n, last_c, px, py, ddh, ddv, pa;
      logic [11:0] pix;
      bit exp_we;
      n = w * h;
      nwr = 0;
      last_c = (n == 0) ? 1 : n + 2;
      @(negedge clk);
      src_h = 10'(sh); src_v = 10'(sv); dst_h = 10'(dh); dst_v = 10'(dv);
      width = 10'(w); height = 10'(h); key_en = ke; key = k; start = 1'b1;
      for (int c = 1; c <= last_c + 1; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (repulse != 0 && c == repulse) begin
            start = 1'b1;
            src_h = 10'(sh + 7); dst_h = 10'(dh + 3); width = 10'(w + 1);
            height = 10'(h + 2); key_en = ~ke;
         end
         if (repulse != 0 && c == repulse + 1) start = 1'b0;
         check_output($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(n > 0 && c <= n + 1));
         check_output($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == last_c));
         if (n > 0 && c <= n) begin
            px = (c - 1) % w; py = (c - 1) / w;
            check_output($sformatf("%s c%0d src_addr", name, c), 32'(src_addr),
                         32'((sh + px) + 320 * (sv + py)));
         end else if (n == 0) begin
            check_output($sformatf("%s c%0d src_addr", name, c), 32'(src_addr), 32'd0);
         end
         exp_we = 1'b0;
         pix = '0;
         ddh = 0; ddv = 0;
         if (n > 0 && c >= 2 && c <= n + 1) begin
            px = (c - 2) % w; py = (c - 2) / w;
            pa = (sh + px) + 320 * (sv + py);
            pix = rom[pa];
            ddh = dh + px; ddv = dv + py;
            exp_we = (ddh < 320) && (ddv < 240) && !(ke && pix == k);
         end
         check_output($sformatf("%s c%0d we", name, c), 32'(we), 32'(exp_we));
         if (exp_we) begin
            nwr++;
            check_output($sformatf("%s c%0d waddr", name, c), 32'(waddr), 32'(ddh + 320 * ddv));
            check_output($sformatf("%s c%0d wdata", name, c), 32'(wdata), 32'(pix));
         end
      end
   endtask

   initial begin
      int nwr, w, h, sh, sv;
      for (int i = 0; i < 76800; i++) rom[i] = 12'(i);

      #12;
      check_output("reset src_addr", 32'(src_addr), 32'd0);
      check_output("reset waddr", 32'(waddr), 32'd0);
      check_output("reset wdata", 32'(wdata), 32'd0);
      check_output("reset we", 32'(we), 32'd0);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      apply_stimulus("copy4x2", 0, 0, 10, 5, 4, 2, 1'b0, 12'h000, 0, nwr);
      check_output("copy4x2 writes", 32'(nwr), 32'd8);

      apply_stimulus("clip", 0, 0, 318, 239, 4, 3, 1'b0, 12'h000, 0, nwr);
      check_output("clip writes", 32'(nwr), 32'd2);

      for (int i = 0; i < 6; i++) rom[320 * 100 + i] = i[0] ? 12'hFFF : 12'h000;
      apply_stimulus("key", 0, 100, 20, 20, 6, 1, 1'b1, 12'h000, 0, nwr);
      check_output("key writes", 32'(nwr), 32'd3);

      apply_stimulus("zero", 3, 3, 0, 0, 0, 7, 1'b0, 12'h000, 0, nwr);
      check_output("zero writes", 32'(nwr), 32'd0);

      apply_stimulus("repulse", 2, 4, 30, 40, 5, 5, 1'b0, 12'h000, 3, nwr);
      check_output("repulse writes", 32'(nwr), 32'd25);

      // Asynchronous reset in cycle 4 of a 3x3 copy.
      @(negedge clk);
      src_h = 10'd1; src_v = 10'd1; dst_h = 10'd5; dst_v = 10'd5;
      width = 10'd3; height = 10'd3; key_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst before we", 32'(we), 32'd1);
      check_output("rst before busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst async we", 32'(we), 32'd0);
      check_output("rst async busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output($sformatf("rst hold%0d done", i), 32'(done), 32'd0);
         check_output($sformatf("rst hold%0d busy", i), 32'(busy), 32'd0);
      end
      rst_n = 1'b1;
      apply_stimulus("after_rst", 1, 1, 5, 5, 3, 3, 1'b0, 12'h000, 0, nwr);
      check_output("after_rst writes", 32'(nwr), 32'd9);

      for (int t = 0; t < 10; t++) begin
         w = $urandom_range(0, 8);
         h = $urandom_range(0, 8);
         sh = $urandom_range(0, 320 - w);
         sv = $urandom_range(0, 240 - h);
         apply_stimulus($sformatf("rand%0d", t), sh, sv,
                        $urandom_range(0, 330), $urandom_range(0, 250), w, h,
                        1'($urandom_range(0, 1)),
                        rom[(sh + $urandom_range(0, 3)) + 320 * sv], 0, nwr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
